// File: rtl/deser8_demux_pkg.sv
// Shared constants and types for the 8-bit serial-to-parallel receiver.
package deser8_demux_pkg;

    // Word width (bits per frame) and slot-counter width.
    localparam int DS_N  = 8;
    localparam int DS_SW = 3;

    // Slot index into the staging register.
    typedef logic [DS_SW-1:0] slot_t;

    // One received parallel word.
    typedef logic [DS_N-1:0]  word_t;

endpackage

// File: rtl/deser8_demux_if.sv
// Serial-in / word-out bundle between the link driver, the receiver and the consumer.
interface deser8_demux_if;
    import deser8_demux_pkg::*;

    logic   din;        // serial data bit
    logic   din_valid;  // din is sampled this cycle
    logic   start;      // frame alignment, forces slot 0
    word_t  q;          // completed word
    logic   q_valid;    // q holds an unconsumed word
    logic   q_ready;    // consumer accepts q
    slot_t  sel;        // slot the next sampled bit lands in
    logic   overrun;    // sticky, a completed word was dropped

    // Link driver / consumer side.
    modport master (
        output din, din_valid, start, q_ready,
        input  q, q_valid, sel, overrun
    );

    // Receiver side.
    modport slave (
        input  din, din_valid, start, q_ready,
        output q, q_valid, sel, overrun
    );

endinterface

// File: rtl/deser8_demux_demux1x8.sv
// Slot decoder: turns a slot index plus enable into a one-hot write-enable
// vector for the staging flops (receive-side mirror of the serializer mux).
module deser8_demux_demux1x8 #(
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic [SW-1:0] i_sel,
    input  logic          i_en,
    output logic [N-1:0]  o_we
);

    // One comparator per slot; at most one bit is set, none when disabled.
    for (genvar g = 0; g < N; g++) begin : g_slot
        assign o_we[g] = i_en && (i_sel == SW'(g));
    end

endmodule

// File: rtl/deser8_demux.sv
// Serial-to-parallel receiver: demultiplexes a bit stream (index 0 first)
// into staging flops under a slot counter and hands completed words to a
// one-word valid/ready output buffer with a sticky overrun flag.
module deser8_demux
    import deser8_demux_pkg::*;
#(
    parameter int N  = DS_N,
    parameter int SW = DS_SW
) (
    input  logic          clk,
    input  logic          rst_n,
    deser8_demux_if.slave bus
);

    // The bus carries package-width types, so the parameters must agree.
    if (N != DS_N || SW != DS_SW || (1 << SW) != N) begin : g_bad_param
        $error("deser8_demux: N/SW must match package and N == 2**SW");
    end

    logic [SW-1:0] r_sel;    // slot for the next sampled bit
    logic [N-2:0]  r_stage;  // slots 0..N-2; the last bit goes straight to q
    logic [N-1:0]  r_q;      // output buffer
    logic          r_qv;     // output buffer occupied
    logic          r_ovr;    // sticky overrun

    logic [SW-1:0] w_slot;   // effective slot this cycle (start forces 0)
    logic [N-1:0]  w_we;     // one-hot staging write enable
    logic          w_done;   // last bit of a frame sampled this cycle
    logic          w_free;   // buffer can take a word this cycle
    logic [N-1:0]  w_word;   // word completed this cycle

    assign w_slot = bus.start ? '0 : r_sel;

    deser8_demux_demux1x8 #(
        .N  (N),
        .SW (SW)
    ) u_demux (
        .i_sel (w_slot),
        .i_en  (bus.din_valid),
        .o_we  (w_we)
    );

    // Writing the top slot is the completion event; no flop is kept for it.
    assign w_done = w_we[N-1];
    assign w_free = !r_qv || bus.q_ready;
    assign w_word = {bus.din, r_stage};

    // Slot counter: wraps naturally at N, start realigns to slot 0.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_sel <= '0;
        else if (bus.din_valid)
            r_sel <= w_slot + SW'(1);
        else if (bus.start)
            r_sel <= '0;
    end

    // Staging flops: each slot captures din only when its enable fires.
    for (genvar g = 0; g < N-1; g++) begin : g_stage
        always_ff @(posedge clk) begin
            if (!rst_n)
                r_stage[g] <= 1'b0;
            else if (w_we[g])
                r_stage[g] <= bus.din;
        end
    end

    // Output word: reloaded only when a frame completes into a free buffer.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_q <= '0;
        else if (w_done && w_free)
            r_q <= w_word;
    end

    // Output valid: set on load, cleared on a consume with no same-cycle load.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_qv <= 1'b0;
        else if (w_done && w_free)
            r_qv <= 1'b1;
        else if (r_qv && bus.q_ready)
            r_qv <= 1'b0;
    end

    // Overrun: a completed word met a full buffer; held until reset.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_ovr <= 1'b0;
        else if (w_done && !w_free)
            r_ovr <= 1'b1;
    end

    assign bus.q       = r_q;
    assign bus.q_valid = r_qv;
    assign bus.sel     = r_sel;
    assign bus.overrun = r_ovr;

endmodule

// File: tb/tb_deser8_demux.sv
// Self-checking bench for deser8_demux: a scoreboard queue holds the words
// the consumer should see, popped on every q_valid && q_ready handshake.
module tb_deser8_demux;

    logic clk;
    logic rst_n;
    int   nvec;
    int   nerr;
    logic [7:0] sb[$];

    deser8_demux_if bus ();

    deser8_demux dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h want 0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle; inputs change just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.q_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.din       = 1'($urandom);
            bus.din_valid = 1'($urandom);
            bus.start     = 1'($urandom);
            tick();
        end
        rst_n = 1'b1;
        bus.din = 1'b0; bus.din_valid = 1'b0; bus.start = 1'b0;
    endtask

    // Send one word index-0 first; optional start on bit 0, random idle
    // cycles, and q_ready raised only alongside the last bit.
    task automatic send_word(input logic [7:0] w, input bit st0, input bit stalls,
                             input bit rdy_last);
        for (int i = 0; i < 8; i++) begin
            if (stalls && $urandom_range(0, 2) == 0) begin
                bus.din = 1'($urandom); bus.din_valid = 1'b0; bus.start = 1'b0;
                tick();
            end
            bus.din       = w[i];
            bus.din_valid = 1'b1;
            bus.start     = st0 && (i == 0);
            if (rdy_last && i == 7) bus.q_ready = 1'b1;
            tick();
        end
        bus.din_valid = 1'b0;
        bus.start     = 1'b0;
        if (rdy_last) bus.q_ready = 1'b0;
    endtask

    // One-cycle consume pulse.
    task automatic consume();
        bus.q_ready = 1'b1;
        tick();
        bus.q_ready = 1'b0;
    endtask

    // Scoreboard: every handshake about to happen on the next edge pops one word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.q_valid === 1'b1 && bus.q_ready === 1'b1) begin
            if (sb.size() == 0)
                chk("sb_extra_word", 32'(bus.q_valid), 32'd0);
            else
                chk("sb_word", 32'(bus.q), 32'(sb.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nvec = 0; nerr = 0;
        bus.din = 1'b0; bus.din_valid = 1'b0; bus.start = 1'b0; bus.q_ready = 1'b0;
        rst_n = 1'b1;

        // Reset with random inputs.
        do_reset();
        chk("rst_q",   32'(bus.q), 32'h00);
        chk("rst_qv",  32'(bus.q_valid), 32'd0);
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_ovr", 32'(bus.overrun), 32'd0);

        // Single frame, held then consumed.
        sb.push_back(8'hA5);
        send_word(8'hA5, 1'b0, 1'b0, 1'b0);
        chk("single_q",  32'(bus.q), 32'hA5);
        chk("single_qv", 32'(bus.q_valid), 32'd1);
        chk("single_sel", 32'(bus.sel), 32'd0);
        consume();
        chk("cons_qv", 32'(bus.q_valid), 32'd0);
        chk("cons_q",  32'(bus.q), 32'hA5);
        bus.q_ready = 1'b1;  // ready with nothing valid: no effect
        tick();
        chk("idle_rdy_qv", 32'(bus.q_valid), 32'd0);
        chk("idle_rdy_q",  32'(bus.q), 32'hA5);

        // Back-to-back with stalls, consumer always ready.
        sb.push_back(8'h3C);
        sb.push_back(8'hF0);
        send_word(8'h3C, 1'b0, 1'b1, 1'b0);
        send_word(8'hF0, 1'b0, 1'b1, 1'b0);
        tick(); tick();
        bus.q_ready = 1'b0;
        chk("b2b_ovr", 32'(bus.overrun), 32'd0);
        chk("b2b_qv",  32'(bus.q_valid), 32'd0);
        chk("b2b_q",   32'(bus.q), 32'hF0);
        chk("b2b_sb",  32'(sb.size()), 32'd0);

        // Overrun: second word dropped while the first is held.
        sb.push_back(8'h11);
        send_word(8'h11, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0, 1'b0);
        chk("ovr_q",   32'(bus.q), 32'h11);
        chk("ovr_qv",  32'(bus.q_valid), 32'd1);
        chk("ovr_flag", 32'(bus.overrun), 32'd1);
        consume();
        sb.push_back(8'h33);
        send_word(8'h33, 1'b0, 1'b0, 1'b0);
        chk("ovr2_q",   32'(bus.q), 32'h33);
        chk("ovr2_flag", 32'(bus.overrun), 32'd1);
        consume();

        // Realignment: 3 partial bits, start alone, then a clean frame.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.din = 1'b1; bus.din_valid = 1'b1;
            tick();
        end
        bus.din_valid = 1'b0;
        chk("partial_sel", 32'(bus.sel), 32'd3);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("realign_sel", 32'(bus.sel), 32'd0);
        sb.push_back(8'h81);
        send_word(8'h81, 1'b0, 1'b0, 1'b0);
        chk("realign_q",  32'(bus.q), 32'h81);
        chk("realign_qv", 32'(bus.q_valid), 32'd1);
        consume();

        // start together with a valid bit: that bit lands in slot 0.
        for (int i = 0; i < 5; i++) begin
            bus.din = 1'($urandom); bus.din_valid = 1'b1;
            tick();
        end
        sb.push_back(8'h7E);
        send_word(8'h7E, 1'b1, 1'b0, 1'b0);
        chk("startv_q",  32'(bus.q), 32'h7E);
        chk("startv_qv", 32'(bus.q_valid), 32'd1);
        consume();

        // Completion with same-cycle consume: reload, valid stays, no overrun.
        do_reset();
        sb.push_back(8'h55);
        send_word(8'h55, 1'b0, 1'b0, 1'b0);
        chk("hold_q", 32'(bus.q), 32'h55);
        sb.push_back(8'hAA);
        send_word(8'hAA, 1'b0, 1'b0, 1'b1);
        chk("same_q",   32'(bus.q), 32'hAA);
        chk("same_qv",  32'(bus.q_valid), 32'd1);
        chk("same_ovr", 32'(bus.overrun), 32'd0);
        consume();

        // Reset mid-frame drops both the held word and the partial frame.
        send_word(8'h99, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.din = 1'b1; bus.din_valid = 1'b1;
            tick();
        end
        do_reset();
        chk("midrst_qv",  32'(bus.q_valid), 32'd0);
        chk("midrst_sel", 32'(bus.sel), 32'd0);
        chk("midrst_q",   32'(bus.q), 32'h00);
        sb.push_back(8'h42);
        send_word(8'h42, 1'b0, 1'b0, 1'b0);
        chk("postrst_q", 32'(bus.q), 32'h42);
        consume();

        tick();
        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
